hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush generator for the 5-stage RV32 core.
- Drives the `stall`/`flush` inputs of IF_ID, ID_EX, EX_MEM and MEM_WB, plus the PC hold.
- Inputs: decode-stage source operands, EX-stage control already registered in ID_EX, memory-busy handshakes and interrupt status.
- Sequential state covers WFI sleep, post-redirect fetch bubbles and a stall-cycle performance counter.

Parameters:
- REDIRECT_BUBBLES, 1: extra cycles of if_id_flush after a taken redirect, to cover fetch latency; legal 0..3.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_raddr1  in  5  rs1 index of the instruction in ID
- id_raddr2  in  5  rs2 index of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_memread  in  1  MemRead of the instruction in EX
- ex_rd  in  5  rd of the instruction in EX
- ex_pcsel  in  1  branch/jump taken, resolved in EX
- ex_csr_return  in  1  mret in EX
- ex_wfi  in  1  WFI in EX
- irq_pending  in  1  enabled interrupt pending, from CSR unit
- im_stall  in  1  instruction memory busy
- dm_stall  in  1  data memory busy
- pc_stall  out  1  hold PC
- if_id_stall  out  1
- if_id_flush  out  1
- id_ex_stall  out  1
- id_ex_flush  out  1
- ex_mem_stall  out  1
- mem_wb_stall  out  1
- sleeping  out  1  core is in WFI sleep
- stall_cycles  out  CNT_W  count of cycles with pc_stall=1

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; state changes only on the rising clk edge.
- Registered state:
  - fsm: RUN / SLEEP / BUBBLE
  - bub_cnt: 2 bits
  - stall_cycles
- Reset values: fsm=RUN, bub_cnt=0, stall_cycles=0.
- While rst=1, all single-bit outputs are forced to 0 combinationally.
- Stall/flush outputs are combinational from the state and current inputs; there is zero-cycle latency to the pipeline registers.
- Derived signals:
  - mem_busy = im_stall | dm_stall
  - redirect = ex_pcsel | ex_csr_return
  - load_use = ex_memread & (ex_rd!=0) & ((id_use_rs1 & id_raddr1==ex_rd) | (id_use_rs2 & id_raddr2==ex_rd))
- Output priority, highest first (all unlisted outputs are 0):
  1. mem_busy: all five stalls=1, both flushes=0. The FSM holds, and bub_cnt holds.
  2. fsm==SLEEP: pc_stall=1, if_id_stall=1, id_ex_flush=1.
  3. redirect: if_id_flush=1, id_ex_flush=1.
  4. fsm==BUBBLE: if_id_flush=1. load_use is ignored because ID holds a bubble.
  5. load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1.
- Transitions, evaluated only when mem_busy=0:
  - RUN, ex_wfi & !irq_pending -> SLEEP.
  - RUN, ex_wfi & irq_pending -> RUN. WFI retires as a NOP.
  - RUN, redirect & REDIRECT_BUBBLES>0 -> BUBBLE, bub_cnt=REDIRECT_BUBBLES-1.
  - BUBBLE:
    - a new redirect reloads bub_cnt=REDIRECT_BUBBLES-1.
    - otherwise, if bub_cnt==0 -> RUN.
    - otherwise bub_cnt decrements.
  - SLEEP, irq_pending -> RUN. Outputs are normal-priority in the first RUN cycle.
  - SLEEP ignores redirect/ex_wfi; EX holds the flushed bubble.
- ex_wfi together with redirect in the same cycle: redirect wins for outputs; the transition goes to BUBBLE, not SLEEP.
- sleeping = (fsm==SLEEP).
- stall_cycles increments by 1 each cycle with pc_stall=1. It wraps modulo 2^CNT_W and is not saturated.
- A reset mid-SLEEP or mid-BUBBLE returns to RUN next edge and drops all stalls.

Decomposition:
- Shared package core_pkg holds:
  - enum hz_state_e {RUN, SLEEP, BUBBLE}
  - REG_ZERO = 5'd0
  - the stall/flush vector typedef, a packed struct of the seven outputs
- One sub-module: hz_perf_cnt (CNT_W-bit enable counter with sync reset), reusable for other perf counters.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_raddr1=5, id_use_rs1=1 -> pc_stall=if_id_stall=id_ex_flush=1 for exactly 1 cycle; stall_cycles +1.
- Load-use with ex_rd=0, id_raddr1=0 -> no stall/flush.
- Redirect: ex_pcsel pulse, REDIRECT_BUBBLES=1 -> if_id_flush=1 for 2 consecutive cycles, id_ex_flush=1 in the first only. With REDIRECT_BUBBLES=0 -> only 1 cycle.
- Redirect plus dm_stall for 3 cycles -> all stalls=1 and no flush for 3 cycles, then redirect flushes apply; BUBBLE length unchanged.
- WFI: ex_wfi=1, irq_pending=0 -> sleeping=1 from next cycle and pc_stall=1 each cycle. irq_pending=1 at cycle 10 -> sleeping=0 at cycle 11. stall_cycles counts the sleep cycles.
- Reset mid-SLEEP -> next cycle sleeping=0, stall_cycles=0. Counter wrap with CNT_W=4: 16 stall cycles -> stall_cycles returns to 0.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared hazard-control types; state enum, x0 index and stall/flush vector
package core_pkg;
  typedef enum logic [1:0] {RUN, SLEEP, BUBBLE} hz_state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_stall;
  } hz_ctl_t;
  localparam hz_ctl_t HZ_NONE  = 7'b0000000;
  localparam hz_ctl_t HZ_MEM   = 7'b1101011;
  localparam hz_ctl_t HZ_HOLD  = 7'b1100100;
  localparam hz_ctl_t HZ_REDIR = 7'b0010100;
  localparam hz_ctl_t HZ_BUB   = 7'b0010000;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs from ID/EX/memories/CSR and stall/flush outputs to the pipeline
//   master: hazard controller side (hazards in, stall/flush/sleep/counter out)
//   slave:  pipeline side (hazards out, stall/flush/sleep/counter in)
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] id_raddr1, id_raddr2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_memread, ex_pcsel, ex_csr_return, ex_wfi;
  logic irq_pending, im_stall, dm_stall;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_stall;
  logic sleeping;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    input  id_raddr1, id_raddr2, ex_rd, id_use_rs1, id_use_rs2, ex_memread, ex_pcsel,
           ex_csr_return, ex_wfi, irq_pending, im_stall, dm_stall,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
           mem_wb_stall, sleeping, stall_cycles
  );
  modport slave (
    output id_raddr1, id_raddr2, ex_rd, id_use_rs1, id_use_rs2, ex_memread, ex_pcsel,
           ex_csr_return, ex_wfi, irq_pending, im_stall, dm_stall,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
           mem_wb_stall, sleeping, stall_cycles
  );
endinterface

// File: rtl/hz_perf_cnt.sv
// hz_perf_cnt: W-bit wrapping event counter; clk, rst (sync, active-high), en (count this cycle), cnt (value)
module hz_perf_cnt #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = en ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush generator for the 5-stage core; clk, rst (sync, active-high), bus (hazard inputs, stall/flush/sleeping/stall_cycles outputs)
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_if.master bus
);
  localparam logic [1:0] BUB_INIT = 2'(REDIRECT_BUBBLES > 0 ? REDIRECT_BUBBLES - 1 : 0);
  hz_state_e state_q, state_d;
  logic [1:0] bub_q, bub_d;
  logic mem_busy, redirect, load_use;
  hz_ctl_t ctl;
  assign mem_busy = bus.im_stall | bus.dm_stall;
  assign redirect = bus.ex_pcsel | bus.ex_csr_return;
  assign load_use = bus.ex_memread && bus.ex_rd != REG_ZERO &&
                    ((bus.id_use_rs1 && bus.id_raddr1 == bus.ex_rd) ||
                     (bus.id_use_rs2 && bus.id_raddr2 == bus.ex_rd));
  // BUBBLE ignores load_use: ID only holds a squashed fetch then
  always_comb
    ctl = rst                ? HZ_NONE  :
          mem_busy           ? HZ_MEM   :
          state_q == SLEEP   ? HZ_HOLD  :
          redirect           ? HZ_REDIR :
          state_q == BUBBLE  ? HZ_BUB   :
          load_use           ? HZ_HOLD  : HZ_NONE;
  // A busy memory freezes the whole pipe, so the FSM freezes with it
  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    if (!mem_busy)
      case (state_q)
        RUN:
          if (redirect) begin
            if (REDIRECT_BUBBLES > 0) begin
              state_d = BUBBLE;
              bub_d   = BUB_INIT;
            end
          end else if (bus.ex_wfi && !bus.irq_pending) state_d = SLEEP;
        BUBBLE:
          if (redirect) bub_d = BUB_INIT;
          else if (bub_q == 2'd0) state_d = RUN;
          else bub_d = bub_q - 2'd1;
        SLEEP:
          if (bus.irq_pending) state_d = RUN;
        default: state_d = RUN;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= RUN;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  assign {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
          bus.id_ex_flush, bus.ex_mem_stall, bus.mem_wb_stall} = ctl;
  assign bus.sleeping = !rst && state_q == SLEEP;
  hz_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .en (ctl.pc_stall),
    .cnt(bus.stall_cycles)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with REDIRECT_BUBBLES=1/CNT_W=32 and REDIRECT_BUBBLES=0/CNT_W=4
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_raddr1, id_raddr2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_memread, ex_pcsel, ex_csr_return, ex_wfi;
  logic irq_pending, im_stall, dm_stall;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  hazard_ctrl_if #(.CNT_W(32)) bus_a ();
  hazard_ctrl_if #(.CNT_W(4))  bus_b ();
  assign {bus_a.id_raddr1, bus_a.id_raddr2, bus_a.ex_rd, bus_a.id_use_rs1, bus_a.id_use_rs2,
          bus_a.ex_memread, bus_a.ex_pcsel, bus_a.ex_csr_return, bus_a.ex_wfi,
          bus_a.irq_pending, bus_a.im_stall, bus_a.dm_stall} =
         {id_raddr1, id_raddr2, ex_rd, id_use_rs1, id_use_rs2, ex_memread, ex_pcsel,
          ex_csr_return, ex_wfi, irq_pending, im_stall, dm_stall};
  assign {bus_b.id_raddr1, bus_b.id_raddr2, bus_b.ex_rd, bus_b.id_use_rs1, bus_b.id_use_rs2,
          bus_b.ex_memread, bus_b.ex_pcsel, bus_b.ex_csr_return, bus_b.ex_wfi,
          bus_b.irq_pending, bus_b.im_stall, bus_b.dm_stall} =
         {id_raddr1, id_raddr2, ex_rd, id_use_rs1, id_use_rs2, ex_memread, ex_pcsel,
          ex_csr_return, ex_wfi, irq_pending, im_stall, dm_stall};
  hazard_ctrl #(.REDIRECT_BUBBLES(1), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
  hazard_ctrl #(.REDIRECT_BUBBLES(0), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));
  typedef struct packed {
    logic [6:0]  o;
    logic        slp;
    logic [31:0] cnt;
  } exp_t;
  exp_t qa[$], qb[$];
  int st[2];
  int bub[2];
  logic [31:0] cnt[2];
  int rbv[2];
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, act, exp, $time);
    end
  endtask
  // Reference model: st 0=RUN 1=SLEEP 2=BUBBLE; o = {pc,ifs,iff,ids,idf,exs,mws}
  function automatic logic [6:0] m_out(input int k);
    logic mb, red, lu;
    mb  = im_stall | dm_stall;
    red = ex_pcsel | ex_csr_return;
    lu  = ex_memread && ex_rd != 0 &&
          ((id_use_rs1 && id_raddr1 == ex_rd) || (id_use_rs2 && id_raddr2 == ex_rd));
    if (rst) return 7'b0000000;
    if (mb) return 7'b1101011;
    if (st[k] == 1) return 7'b1100100;
    if (red) return 7'b0010100;
    if (st[k] == 2) return 7'b0010000;
    if (lu) return 7'b1100100;
    return 7'b0000000;
  endfunction
  task automatic m_update(input int k, input logic pc);
    if (rst) begin
      st[k] = 0; bub[k] = 0; cnt[k] = 0;
    end else begin
      if (pc) cnt[k] = cnt[k] + 1;
      if (!(im_stall | dm_stall)) begin
        if (st[k] == 0) begin
          if (ex_pcsel | ex_csr_return) begin
            if (rbv[k] > 0) begin st[k] = 2; bub[k] = rbv[k] - 1; end
          end else if (ex_wfi && !irq_pending) st[k] = 1;
        end else if (st[k] == 2) begin
          if (ex_pcsel | ex_csr_return) bub[k] = rbv[k] - 1;
          else if (bub[k] == 0) st[k] = 0;
          else bub[k] = bub[k] - 1;
        end else if (irq_pending) st[k] = 0;
      end
    end
  endtask
  task automatic step();
    exp_t ea, eb;
    ea = '{o: m_out(0), slp: !rst && st[0] == 1, cnt: cnt[0]};
    eb = '{o: m_out(1), slp: !rst && st[1] == 1, cnt: cnt[1] & 32'hF};
    qa.push_back(ea);
    qb.push_back(eb);
    @(negedge clk);
    ea = qa.pop_front();
    eb = qb.pop_front();
    chk("a_ctl", 32'({bus_a.pc_stall, bus_a.if_id_stall, bus_a.if_id_flush, bus_a.id_ex_stall,
                      bus_a.id_ex_flush, bus_a.ex_mem_stall, bus_a.mem_wb_stall}), 32'(ea.o));
    chk("a_sleeping", 32'(bus_a.sleeping), 32'(ea.slp));
    chk("a_stall_cycles", bus_a.stall_cycles, ea.cnt);
    chk("b_ctl", 32'({bus_b.pc_stall, bus_b.if_id_stall, bus_b.if_id_flush, bus_b.id_ex_stall,
                      bus_b.id_ex_flush, bus_b.ex_mem_stall, bus_b.mem_wb_stall}), 32'(eb.o));
    chk("b_sleeping", 32'(bus_b.sleeping), 32'(eb.slp));
    chk("b_stall_cycles", 32'(bus_b.stall_cycles), eb.cnt);
    m_update(0, ea.o[6]);
    m_update(1, eb.o[6]);
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {id_raddr1, id_raddr2, ex_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_memread, ex_pcsel, ex_csr_return, ex_wfi} = '0;
    {irq_pending, im_stall, dm_stall} = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    rbv[0] = 1; rbv[1] = 0;
    for (int k = 0; k < 2; k++) begin st[k] = 0; bub[k] = 0; cnt[k] = 0; end
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // outputs must stay low under reset even with a live load-use hazard
    ex_memread = 1; ex_rd = 5; id_raddr1 = 5; id_use_rs1 = 1;
    step();
    step();
    rst = 1'b0;
    chk("reset_cnt", bus_a.stall_cycles, 32'd0);
    step();
    idle();
    step();
    chk("load_use_cnt", bus_a.stall_cycles, 32'd1);
    ex_memread = 1; ex_rd = 0; id_raddr1 = 0; id_use_rs1 = 1;
    step();
    idle();
    ex_memread = 1; ex_rd = 7; id_raddr2 = 7; id_use_rs2 = 1;
    step();
    idle();
    ex_pcsel = 1;
    step();
    idle();
    repeat (3) step();
    ex_csr_return = 1;
    step();
    idle();
    repeat (2) step();
    ex_pcsel = 1; dm_stall = 1;
    repeat (3) step();
    dm_stall = 0;
    step();
    idle();
    repeat (3) step();
    ex_wfi = 1;
    step();
    ex_wfi = 0;
    repeat (9) step();
    irq_pending = 1;
    step();
    irq_pending = 0;
    repeat (2) step();
    ex_wfi = 1; irq_pending = 1;
    step();
    idle();
    ex_wfi = 1; ex_pcsel = 1;
    step();
    idle();
    repeat (2) step();
    ex_wfi = 1;
    step();
    idle();
    repeat (3) step();
    do_reset();
    chk("rst_sleep_sleeping", 32'(bus_a.sleeping), 32'd0);
    chk("rst_sleep_cnt", bus_a.stall_cycles, 32'd0);
    step();
    ex_pcsel = 1;
    step();
    idle();
    do_reset();
    ex_memread = 1; ex_rd = 9; id_raddr1 = 9; id_use_rs1 = 1;
    repeat (16) step();
    idle();
    chk("wrap_b_cnt", 32'(bus_b.stall_cycles), 32'd0);
    chk("wrap_a_cnt", bus_a.stall_cycles, 32'd16);
    repeat (400) begin
      rst           = ($urandom % 60) == 0;
      im_stall      = ($urandom % 10) == 0;
      dm_stall      = ($urandom % 10) == 0;
      ex_pcsel      = ($urandom % 7) == 0;
      ex_csr_return = ($urandom % 25) == 0;
      ex_wfi        = ($urandom % 12) == 0;
      irq_pending   = ($urandom % 5) == 0;
      ex_memread    = ($urandom % 3) == 0;
      ex_rd         = 5'($urandom_range(0, 3));
      id_raddr1     = 5'($urandom_range(0, 3));
      id_raddr2     = 5'($urandom_range(0, 3));
      id_use_rs1    = 1'($urandom);
      id_use_rs2    = 1'($urandom);
      step();
    end
    rst = 1'b0;
    idle();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
